button_report_scheduler: RTL and testbench

//  Periodic poller for the N_CH mouse-button press counters. Each poll round

---
 rtl/button_report_scheduler.sv | 165 ++++++++++++++++
 tb/tb_button_report_scheduler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_report_scheduler.sv
// Periodic poller for the per-button press counters: snapshots each non-zero
// count, emits it on a valid/ready report port, then pulses that counter's clear.
module button_report_scheduler #(
  parameter int N_CH     = 3,
  parameter int CNT_W    = 8,
  parameter int CH_W     = 2,
  parameter int POLL_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [N_CH*CNT_W-1:0] cnt_bus,
  output logic [N_CH-1:0]       cnt_clr,
  output logic                  rpt_valid,
  input  logic                  rpt_ready,
  output logic [CH_W-1:0]       rpt_ch,
  output logic [CNT_W-1:0]      rpt_count,
  output logic                  rpt_sat,
  output logic                  busy
);

  // state | meaning
  // IDLE  | waiting for a poll tick (or a tick merged during the last round)
  // SCAN  | sampling counter ptr; zero skips ahead, non-zero captures a report
  // SEND  | report held on the port until accepted; clear pulsed on entry

  localparam int              DIV_W    = (POLL_DIV > 2) ? $clog2(POLL_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(POLL_DIV - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [CH_W-1:0]   ptr, ptr_nxt;
  logic [DIV_W-1:0]  div;
  logic              pend, pend_nxt;
  logic              tick;
  logic [CNT_W-1:0]  cur_cnt;
  logic              ptr_ok;
  logic [N_CH-1:0]   ptr_dec;
  logic [N_CH-1:0]   clr_nxt;
  logic              valid_nxt;
  logic [CH_W-1:0]   ch_nxt;
  logic [CNT_W-1:0]  count_nxt;
  logic              sat_nxt;

  assign tick = enable && (div == DIV_LAST);
  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      div <= '0;
    end else if (enable) begin
      div <= tick ? '0 : div + DIV_W'(1);
    end
  end

  // Channel select; an index beyond N_CH-1 leaves ptr_ok low.
  always_comb begin
    cur_cnt = '0;
    ptr_ok  = 1'b0;
    ptr_dec = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ptr == CH_W'(k)) begin
        cur_cnt    = cnt_bus[k*CNT_W +: CNT_W];
        ptr_ok     = 1'b1;
        ptr_dec[k] = 1'b1;
      end
    end
  end

  // Pend is one deep; it only lives while a round is running.
  always_comb begin
    pend_nxt = pend;
    if (!enable) begin
      pend_nxt = 1'b0;
    end else if (state == IDLE) begin
      pend_nxt = 1'b0;
    end else if (tick) begin
      pend_nxt = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    valid_nxt = rpt_valid;
    ch_nxt    = rpt_ch;
    count_nxt = rpt_count;
    sat_nxt   = rpt_sat;
    clr_nxt   = '0;
    case (state)
      IDLE: begin
        if ((pend && enable) || tick) begin
          state_nxt = SCAN;
          ptr_nxt   = '0;
        end
      end
      SCAN: begin
        if (!ptr_ok) begin
          state_nxt = IDLE;
          ptr_nxt   = '0;
        end else if (cur_cnt == '0) begin
          if (ptr == CH_LAST) begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt = ptr + CH_W'(1);
          end
        end else begin
          count_nxt = cur_cnt;
          ch_nxt    = ptr;
          sat_nxt   = &cur_cnt;
          valid_nxt = 1'b1;
          clr_nxt   = ptr_dec;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (rpt_ready) begin
          valid_nxt = 1'b0;
          if ((ptr == CH_LAST) || !ptr_ok) begin
            state_nxt = IDLE;
            ptr_nxt   = '0;
          end else begin
            state_nxt = SCAN;
            ptr_nxt   = ptr + CH_W'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        ptr_nxt   = '0;
        valid_nxt = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      pend      <= 1'b0;
      cnt_clr   <= '0;
      rpt_valid <= 1'b0;
      rpt_ch    <= '0;
      rpt_count <= '0;
      rpt_sat   <= 1'b0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      pend      <= pend_nxt;
      cnt_clr   <= clr_nxt;
      rpt_valid <= valid_nxt;
      rpt_ch    <= ch_nxt;
      rpt_count <= count_nxt;
      rpt_sat   <= sat_nxt;
    end
  end

endmodule

// File: tb/tb_button_report_scheduler.sv
// Bench for button_report_scheduler: directed scenarios plus randomized rounds,
// checked against a report queue, a counter model and tick arithmetic.
module tb_button_report_scheduler;
  localparam int N_CH     = 3;
  localparam int CNT_W    = 8;
  localparam int CH_W     = 2;
  localparam int POLL_DIV = 8;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  enable;
  logic [N_CH*CNT_W-1:0] cnt_bus;
  logic [N_CH-1:0]       cnt_clr;
  logic                  rpt_valid;
  logic                  rpt_ready;
  logic [CH_W-1:0]       rpt_ch;
  logic [CNT_W-1:0]      rpt_count;
  logic                  rpt_sat;
  logic                  busy;

  button_report_scheduler #(
    .N_CH(N_CH), .CNT_W(CNT_W), .CH_W(CH_W), .POLL_DIV(POLL_DIV)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .cnt_bus(cnt_bus), .cnt_clr(cnt_clr),
    .rpt_valid(rpt_valid), .rpt_ready(rpt_ready), .rpt_ch(rpt_ch),
    .rpt_count(rpt_count), .rpt_sat(rpt_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  // Button counter model: values set by the stimulus, zeroed by cnt_clr.
  logic [CNT_W-1:0] cnt [N_CH];
  always_comb begin
    cnt_bus = '0;
    for (int k = 0; k < N_CH; k++) cnt_bus[k*CNT_W +: CNT_W] = cnt[k];
  end

  typedef struct { int ch; int count; } rpt_t;
  rpt_t exp_q[$];

  int checks = 0, errors = 0;
  int en_edges = 0, accepts = 0, busy_cyc = 0, stall_cyc = 0, busy_rises = 0, valid_cyc = 0;
  int clr_cnt [N_CH];
  logic             prev_hold = 1'b0, prev_busy = 1'b0;
  logic [CH_W-1:0]  prev_ch = '0;
  logic [CNT_W-1:0] prev_count = '0;
  logic             prev_sat = 1'b0;
  logic [N_CH-1:0]  prev_clr = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-cycle observation of the DUT outputs.
  task automatic sample();
    rpt_t e;
    for (int k = 0; k < N_CH; k++) begin
      if (cnt_clr[k] === 1'b1) begin
        cnt[k] = '0;
        clr_cnt[k]++;
      end
    end
    if (!rst) begin
      en_edges  = 0;
      prev_hold = 1'b0;
      prev_busy = 1'b0;
      prev_clr  = '0;
      return;
    end
    if (enable) en_edges++;
    if (busy) busy_cyc++;
    if (busy && !prev_busy) busy_rises++;
    prev_busy = busy;
    if (prev_hold) begin
      chk("hold_valid", 32'(rpt_valid), 1);
      chk("hold_ch", 32'(rpt_ch), 32'(prev_ch));
      chk("hold_count", 32'(rpt_count), 32'(prev_count));
      chk("hold_sat", 32'(rpt_sat), 32'(prev_sat));
    end
    if (rpt_valid) begin
      valid_cyc++;
      if (!rpt_ready) stall_cyc++;
      chk("count_nonzero", 32'(rpt_count != '0), 1);
      chk("sat_flag", 32'(rpt_sat), 32'(rpt_count == CNT_W'(CNT_MAX)));
    end
    if (cnt_clr != '0) begin
      chk("clr_onehot", 32'($onehot(cnt_clr)), 1);
      chk("clr_channel", 32'(cnt_clr), (32'd1 << rpt_ch));
      chk("clr_with_valid", 32'(rpt_valid), 1);
      chk("clr_one_cycle", 32'(prev_clr), 0);
    end
    if (rpt_valid && rpt_ready) begin
      accepts++;
      chk("queue_has_entry", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("rpt_ch", 32'(rpt_ch), e.ch);
        chk("rpt_count", 32'(rpt_count), e.count);
        chk("rpt_sat", 32'(rpt_sat), 32'(e.count == CNT_MAX));
      end
    end
    prev_hold  = rpt_valid && !rpt_ready;
    prev_ch    = rpt_ch;
    prev_count = rpt_count;
    prev_sat   = rpt_sat;
    prev_clr   = cnt_clr;
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_busy(input int max, output int n);
    n = 0;
    while (!busy && n < max) begin step(); n++; end
    chk("busy_within_bound", 32'(busy), 1);
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin step(); n++; end
    chk("idle_within_bound", 32'(busy), 0);
  endtask

  task automatic wait_valid(input int max);
    int n = 0;
    while (!rpt_valid && n < max) begin step(); n++; end
    chk("valid_within_bound", 32'(rpt_valid), 1);
  endtask

  // Loads the counters and queues the reports one round should produce.
  task automatic set_counts(input logic [CNT_W-1:0] c0, c1, c2, output int nz);
    cnt[0] = c0; cnt[1] = c1; cnt[2] = c2;
    nz = 0;
    for (int k = 0; k < N_CH; k++) begin
      if (cnt[k] != '0) begin
        exp_q.push_back('{k, int'(cnt[k])});
        nz++;
      end
    end
  endtask

  initial begin
    int n, nz, lat, a0, b0, s0, r0, v0, c0, c1, c2;
    logic [CNT_W-1:0] rc [N_CH];

    for (int k = 0; k < N_CH; k++) begin cnt[k] = '0; clr_cnt[k] = 0; end
    rst = 1'b0; enable = 1'b0; rpt_ready = 1'b1;

    // T1: reset
    step(4);
    chk("t1_valid", 32'(rpt_valid), 0);
    chk("t1_clr", 32'(cnt_clr), 0);
    chk("t1_ch", 32'(rpt_ch), 0);
    chk("t1_count", 32'(rpt_count), 0);
    chk("t1_sat", 32'(rpt_sat), 0);
    chk("t1_busy", 32'(busy), 0);

    // T2: single report on ch1, first tick after POLL_DIV enabled cycles
    set_counts(0, 5, 0, nz);
    rst = 1'b1; enable = 1'b1;
    lat = POLL_DIV - (en_edges % POLL_DIV);
    a0 = accepts; b0 = busy_cyc; c1 = clr_cnt[1];
    wait_busy(4*POLL_DIV, n);
    chk("t2_tick_latency", n, lat);
    enable = 1'b0;
    wait_idle(100);
    chk("t2_reports", accepts - a0, 1);
    chk("t2_clr_ch1", clr_cnt[1] - c1, 1);
    chk("t2_busy_cycles", busy_cyc - b0, N_CH + nz);
    chk("t2_queue_empty", exp_q.size(), 0);

    // T3: backpressure on ch0, then saturated ch2
    rpt_ready = 1'b0;
    set_counts(3, 0, 8'hFF, nz);
    enable = 1'b1;
    a0 = accepts; b0 = busy_cyc; s0 = stall_cyc; c0 = clr_cnt[0]; c2 = clr_cnt[2];
    wait_valid(4*POLL_DIV);
    for (int i = 0; i < 10; i++) begin
      chk("t3_held_valid", 32'(rpt_valid), 1);
      chk("t3_held_ch", 32'(rpt_ch), 0);
      chk("t3_held_count", 32'(rpt_count), 3);
      step();
    end
    rpt_ready = 1'b1; enable = 1'b0;
    wait_idle(100);
    chk("t3_reports", accepts - a0, 2);
    chk("t3_clr_ch0", clr_cnt[0] - c0, 1);
    chk("t3_clr_ch2", clr_cnt[2] - c2, 1);
    chk("t3_busy_cycles", busy_cyc - b0, N_CH + nz + (stall_cyc - s0));
    chk("t3_queue_empty", exp_q.size(), 0);

    // T4: three ticks with all counts zero; each round is the tick cycle plus N_CH scans
    set_counts(0, 0, 0, nz);
    r0 = busy_rises; b0 = busy_cyc; v0 = valid_cyc;
    c0 = clr_cnt[0] + clr_cnt[1] + clr_cnt[2];
    enable = 1'b1;
    step(3*POLL_DIV);
    enable = 1'b0;
    wait_idle(50);
    chk("t4_rounds", busy_rises - r0, 3);
    chk("t4_busy_cycles", busy_cyc - b0, 3*N_CH);
    chk("t4_no_valid", valid_cyc - v0, 0);
    chk("t4_no_clr", clr_cnt[0] + clr_cnt[1] + clr_cnt[2] - c0, 0);

    // T5: enable dropped mid-round after a merged tick
    rpt_ready = 1'b0;
    set_counts(2, 7, 1, nz);
    a0 = accepts; r0 = busy_rises;
    enable = 1'b1;
    wait_valid(4*POLL_DIV);
    step(10);
    enable = 1'b0;
    step(2);
    rpt_ready = 1'b1;
    wait_idle(100);
    chk("t5_reports", accepts - a0, 3);
    chk("t5_one_round", busy_rises - r0, 1);
    r0 = busy_rises;
    step(3*POLL_DIV);
    chk("t5_no_round_disabled", busy_rises - r0, 0);
    lat = POLL_DIV - (en_edges % POLL_DIV);
    enable = 1'b1;
    wait_busy(4*POLL_DIV, n);
    chk("t5_resume_latency", n, lat);
    enable = 1'b0;
    wait_idle(50);

    // T6: reset while a report is held
    rpt_ready = 1'b0;
    set_counts(0, 9, 0, nz);
    a0 = accepts; c1 = clr_cnt[1];
    enable = 1'b1;
    wait_valid(4*POLL_DIV);
    rst = 1'b0;
    step();
    exp_q.delete();
    chk("t6_valid", 32'(rpt_valid), 0);
    chk("t6_clr", 32'(cnt_clr), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_count", 32'(rpt_count), 0);
    rst = 1'b1; enable = 1'b0; rpt_ready = 1'b1;
    step(5);
    chk("t6_no_accept", accepts - a0, 0);
    chk("t6_single_clr", clr_cnt[1] - c1, 1);
    set_counts(0, 0, 0, nz);

    // Randomized rounds with random counts and random ready
    for (int r = 0; r < 10; r++) begin
      for (int k = 0; k < N_CH; k++) begin
        case ($urandom_range(0, 3))
          0: rc[k] = '0;
          1: rc[k] = CNT_W'(CNT_MAX);
          default: rc[k] = CNT_W'($urandom_range(1, CNT_MAX - 1));
        endcase
      end
      set_counts(rc[0], rc[1], rc[2], nz);
      a0 = accepts; b0 = busy_cyc; s0 = stall_cyc;
      enable = 1'b1;
      wait_busy(2*POLL_DIV + 2, n);
      enable = 1'b0;
      n = 0;
      while (busy && n < 200) begin
        rpt_ready = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      chk("rand_idle", 32'(busy), 0);
      chk("rand_reports", accepts - a0, nz);
      chk("rand_queue_empty", exp_q.size(), 0);
      chk("rand_cleared", 32'({cnt[0], cnt[1], cnt[2]}), 0);
      chk("rand_busy_cycles", busy_cyc - b0, N_CH + nz + (stall_cyc - s0));
      rpt_ready = 1'b1;
      step(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
